// File: rtl/cpu_control_rtype.sv
// ============================================================================
// cpu_control_rtype -- single-cycle 32-bit MIPS-subset processor
//
// Purpose:
//   Fetches, decodes and executes one instruction per clk_CPU cycle. Supported
//   instructions: R-type add/sub/and/or/nor/slt, addi, lw, sw, beq, j (and jal
//   when the JAL_EN macro is defined). The registered write-back value of the
//   last executed instruction is exposed on resultado.
//
// Ports:
//   clk_CPU    in   1   system clock, all state updates on the rising edge
//   rst_CPU    in   1   asynchronous active-high reset (PC and resultado only)
//   resultado  out  32  registered write-back / effective address / rs-rt
//
// Parameters:
//   IM_DEPTH   words in IM.instBank   (power of two)
//   DM_DEPTH   words in DM.dataMemory (power of two)
//
// Configuration macro:
//   JAL_EN     when defined, opcode 000011 (jal) writes PC+4 to $31 and jumps;
//              when undefined, opcode 000011 executes as a nop.
//
// Memories are never cleared by reset; their contents come from preload
// through the fixed hierarchical names BR.registerBank, IM.instBank and
// DM.dataMemory.
// ============================================================================

// Register bank: 32x32, two combinational read ports, one synchronous write.
module cpu_rtype_regbank (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registerBank [0:31];

    // Write port; register 0 is hard-wired to zero so writes to it are dropped.
    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            registerBank[wa] <= wd;
        end
    end

    // Read port 1 with register-0 forced to zero regardless of array contents.
    always_comb begin
        if (ra1 == 5'd0) begin
            rd1 = 32'd0;
        end else begin
            rd1 = registerBank[ra1];
        end
    end

    // Read port 2 with register-0 forced to zero regardless of array contents.
    always_comb begin
        if (ra2 == 5'd0) begin
            rd2 = 32'd0;
        end else begin
            rd2 = registerBank[ra2];
        end
    end
endmodule

// Instruction memory: combinational fetch; the load port is tied off in the
// core and exists so the array has a synthesizable writer.
module cpu_rtype_imem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    logic [31:0] instBank [0:DEPTH-1];

    // Optional load port (unused in normal operation).
    always_ff @(posedge clk) begin
        if (load_we) begin
            instBank[load_addr] <= load_data;
        end
    end

    assign instr = instBank[addr];
endmodule

// Data memory: combinational read, write on the rising edge.
module cpu_rtype_dmem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] dataMemory [0:DEPTH-1];

    // Store port.
    always_ff @(posedge clk) begin
        if (we) begin
            dataMemory[addr] <= wdata;
        end
    end

    assign rdata = dataMemory[addr];
endmodule

module cpu_control_rtype #(
    parameter int IM_DEPTH = 64,
    parameter int DM_DEPTH = 64
) (
    input  logic        clk_CPU,
    input  logic        rst_CPU,
    output logic [31:0] resultado
);
    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int DM_AW = $clog2(DM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    // ALU operation class from the main decoder.
    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] instr_s;

    logic [5:0]  opcode_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [5:0]  funct_s;
    logic [31:0] imm_ext_s;

    logic        reg_write_s;
    logic        reg_dst_s;
    logic        alu_src_s;
    logic        mem_to_reg_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        jump_s;
    logic        jal_s;
    logic [1:0]  alu_op_s;

    logic [2:0]  alu_ctl_s;
    logic        funct_ok_s;
    logic        reg_write_eff_s;

    logic [31:0] rs_data_s;
    logic [31:0] rt_data_s;
    logic [31:0] alu_b_s;
    logic [31:0] alu_result_s;
    logic [31:0] dm_rdata_s;
    logic [31:0] wb_data_s;
    logic [4:0]  wb_addr_s;
    logic [31:0] res_next_s;

    assign opcode_s   = instr_s[31:26];
    assign rs_s       = instr_s[25:21];
    assign rt_s       = instr_s[20:16];
    assign rd_s       = instr_s[15:11];
    assign funct_s    = instr_s[5:0];
    assign imm_ext_s  = {{16{instr_s[15]}}, instr_s[15:0]};
    assign pc_plus4_s = pc_r + 32'd4;

    cpu_rtype_imem #(.DEPTH(IM_DEPTH)) IM (
        .clk       (clk_CPU),
        .load_we   (1'b0),
        .load_addr ({IM_AW{1'b0}}),
        .load_data (32'd0),
        .addr      (pc_r[IM_AW+1:2]),
        .instr     (instr_s)
    );

    cpu_rtype_regbank BR (
        .clk (clk_CPU),
        .we  (reg_write_eff_s),
        .ra1 (rs_s),
        .ra2 (rt_s),
        .wa  (wb_addr_s),
        .wd  (wb_data_s),
        .rd1 (rs_data_s),
        .rd2 (rt_data_s)
    );

    cpu_rtype_dmem #(.DEPTH(DM_DEPTH)) DM (
        .clk   (clk_CPU),
        .we    (mem_write_s),
        .addr  (alu_result_s[DM_AW+1:2]),
        .wdata (rt_data_s),
        .rdata (dm_rdata_s)
    );

    // Main control: opcode to datapath steering; unknown opcodes fall to nop.
    always_comb begin
        reg_write_s  = 1'b0;
        reg_dst_s    = 1'b0;
        alu_src_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_write_s  = 1'b0;
        branch_s     = 1'b0;
        jump_s       = 1'b0;
        jal_s        = 1'b0;
        alu_op_s     = AOP_ADD;
        case (opcode_s)
            OP_RTYPE: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                alu_op_s    = AOP_FUNCT;
            end
            OP_ADDI: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
            end
            OP_LW: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                mem_to_reg_s = 1'b1;
            end
            OP_SW: begin
                alu_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            OP_BEQ: begin
                branch_s = 1'b1;
                alu_op_s = AOP_SUB;
            end
            OP_J: begin
                jump_s = 1'b1;
            end
`ifdef JAL_EN
            OP_JAL: begin
                jump_s      = 1'b1;
                jal_s       = 1'b1;
                reg_write_s = 1'b1;
            end
`endif
            default: begin
                reg_write_s = 1'b0;
            end
        endcase
    end

    // ALU control: funct decode for R-type; unsupported funct suppresses the write.
    always_comb begin
        alu_ctl_s  = ALU_ADD;
        funct_ok_s = 1'b1;
        case (alu_op_s)
            AOP_ADD: alu_ctl_s = ALU_ADD;
            AOP_SUB: alu_ctl_s = ALU_SUB;
            AOP_FUNCT: begin
                case (funct_s)
                    6'b100000: alu_ctl_s = ALU_ADD;
                    6'b100010: alu_ctl_s = ALU_SUB;
                    6'b100100: alu_ctl_s = ALU_AND;
                    6'b100101: alu_ctl_s = ALU_OR;
                    6'b100111: alu_ctl_s = ALU_NOR;
                    6'b101010: alu_ctl_s = ALU_SLT;
                    default:   funct_ok_s = 1'b0;
                endcase
            end
            default: alu_ctl_s = ALU_ADD;
        endcase
    end

    assign alu_b_s = alu_src_s ? imm_ext_s : rt_data_s;

    // ALU: 32-bit wrap-around arithmetic, signed compare for slt.
    always_comb begin
        case (alu_ctl_s)
            ALU_ADD: alu_result_s = rs_data_s + alu_b_s;
            ALU_SUB: alu_result_s = rs_data_s - alu_b_s;
            ALU_AND: alu_result_s = rs_data_s & alu_b_s;
            ALU_OR:  alu_result_s = rs_data_s | alu_b_s;
            ALU_NOR: alu_result_s = ~(rs_data_s | alu_b_s);
            ALU_SLT: alu_result_s = ($signed(rs_data_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
            default: alu_result_s = 32'd0;
        endcase
    end

    // Write-back selection shared by the register bank and resultado.
    always_comb begin
        reg_write_eff_s = reg_write_s & funct_ok_s;
        if (jal_s) begin
            wb_data_s = pc_plus4_s;
            wb_addr_s = 5'd31;
        end else if (mem_to_reg_s) begin
            wb_data_s = dm_rdata_s;
            wb_addr_s = rt_s;
        end else if (reg_dst_s) begin
            wb_data_s = alu_result_s;
            wb_addr_s = rd_s;
        end else begin
            wb_data_s = alu_result_s;
            wb_addr_s = rt_s;
        end
    end

    // Observed result: write-back data, store address or beq difference; else hold.
    always_comb begin
        if (reg_write_eff_s) begin
            res_next_s = wb_data_s;
        end else if (mem_write_s || branch_s) begin
            res_next_s = alu_result_s;
        end else begin
            res_next_s = resultado;
        end
    end

    // Next PC: jump has priority, beq taken when the ALU difference is zero.
    always_comb begin
        if (jump_s) begin
            pc_next_s = {pc_plus4_s[31:28], instr_s[25:0], 2'b00};
        end else if (branch_s && (alu_result_s == 32'd0)) begin
            pc_next_s = pc_plus4_s + {imm_ext_s[29:0], 2'b00};
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Architectural state: PC and resultado, asynchronously reset.
    always_ff @(posedge clk_CPU or posedge rst_CPU) begin
        if (rst_CPU) begin
            pc_r      <= 32'd0;
            resultado <= 32'd0;
        end else begin
            pc_r      <= pc_next_s;
            resultado <= res_next_s;
        end
    end
endmodule

// File: tb/tb_cpu_control_rtype.sv
// Directed bench for cpu_control_rtype: preloads program/registers
// hierarchically, then steps one instruction per clock and checks resultado,
// PC and architectural state against hand-computed values.
module tb_cpu_control_rtype;
    logic        clk_CPU;
    logic        rst_CPU;
    logic [31:0] resultado;

    int n_pass;
    int n_fail;
    int n_total;

    cpu_control_rtype #(.IM_DEPTH(64), .DM_DEPTH(64)) dut (
        .clk_CPU   (clk_CPU),
        .rst_CPU   (rst_CPU),
        .resultado (resultado)
    );

    initial clk_CPU = 1'b0;
    always #5 clk_CPU = ~clk_CPU;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_CPU);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        rst_CPU = 1'b1;

        for (int i = 0; i < 64; i++) begin
            dut.IM.instBank[i]   = 32'd0;
            dut.DM.dataMemory[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) begin
            dut.BR.registerBank[i] = 32'd0;
        end
        dut.BR.registerBank[1] = 32'd5;
        dut.BR.registerBank[2] = 32'd3;

        dut.IM.instBank[0]  = rtype(5'd1, 5'd2, 5'd3,  6'b100000); // add $3,$1,$2
        dut.IM.instBank[1]  = rtype(5'd1, 5'd2, 5'd4,  6'b100010); // sub $4
        dut.IM.instBank[2]  = rtype(5'd1, 5'd2, 5'd9,  6'b100100); // and $9
        dut.IM.instBank[3]  = rtype(5'd1, 5'd2, 5'd10, 6'b100101); // or $10
        dut.IM.instBank[4]  = rtype(5'd1, 5'd2, 5'd11, 6'b100111); // nor $11
        dut.IM.instBank[5]  = rtype(5'd2, 5'd1, 5'd5,  6'b101010); // slt $5,$2,$1
        dut.IM.instBank[6]  = rtype(5'd1, 5'd2, 5'd12, 6'b101010); // slt $12,$1,$2
        dut.IM.instBank[7]  = rtype(5'd1, 5'd2, 5'd0,  6'b100000); // add $0,$1,$2
        dut.IM.instBank[8]  = rtype(5'd0, 5'd0, 5'd6,  6'b100000); // add $6,$0,$0
        dut.IM.instBank[9]  = itype(6'b101011, 5'd0, 5'd1, 16'd8);  // sw $1,8($0)
        dut.IM.instBank[10] = itype(6'b100011, 5'd0, 5'd7, 16'd8);  // lw $7,8($0)
        dut.IM.instBank[11] = itype(6'b001000, 5'd0, 5'd8, 16'hFFFF); // addi $8,$0,-1
        dut.IM.instBank[12] = itype(6'b000100, 5'd1, 5'd1, 16'd2);  // beq taken (0x30)
        dut.IM.instBank[13] = itype(6'b001000, 5'd0, 5'd13, 16'h0055);
        dut.IM.instBank[14] = itype(6'b001000, 5'd0, 5'd13, 16'h0055);
        dut.IM.instBank[15] = itype(6'b000100, 5'd1, 5'd2, 16'd5);  // beq not taken (0x3C)
        dut.IM.instBank[16] = itype(6'b001000, 5'd0, 5'd14, 16'h0077);
        dut.IM.instBank[17] = jtype(6'b000011, 26'h12);             // jal/nop at 0x44
        dut.IM.instBank[18] = jtype(6'b000010, 26'h14);             // j 0x50
        dut.IM.instBank[19] = itype(6'b001000, 5'd0, 5'd13, 16'h0055);
        dut.IM.instBank[20] = itype(6'b001000, 5'd15, 5'd15, 16'd1); // addi $15,$15,1
        dut.IM.instBank[21] = jtype(6'b000010, 26'h14);             // j 0x50 (loop)

        #2;
        check("reset_res", resultado, 32'd0);
        check("reset_pc", dut.pc_r, 32'd0);
        step();
        check("reset_hold_pc", dut.pc_r, 32'd0);
        @(negedge clk_CPU);
        rst_CPU = 1'b0;

        step(); check("add_res", resultado, 32'd8);
        check("add_pc", dut.pc_r, 32'h4);
        check("add_reg3", dut.BR.registerBank[3], 32'd8);
        step(); check("sub_res", resultado, 32'd2);
        step(); check("and_res", resultado, 32'd1);
        step(); check("or_res", resultado, 32'd7);
        step(); check("nor_res", resultado, 32'hFFFFFFF8);
        check("nor_reg11", dut.BR.registerBank[11], 32'hFFFFFFF8);
        step(); check("slt_true_res", resultado, 32'd1);
        step(); check("slt_false_res", resultado, 32'd0);
        check("slt_reg5", dut.BR.registerBank[5], 32'd1);
        step(); check("add_r0_pc", dut.pc_r, 32'h20);
        check("r0_stays_zero", dut.BR.registerBank[0], 32'd0);
        step(); check("add_zero_res", resultado, 32'd0);
        check("add_zero_reg6", dut.BR.registerBank[6], 32'd0);
        step(); check("sw_res", resultado, 32'd8);
        check("sw_mem", dut.DM.dataMemory[2], 32'd5);
        step(); check("lw_res", resultado, 32'd5);
        check("lw_reg7", dut.BR.registerBank[7], 32'd5);
        step(); check("addi_neg_res", resultado, 32'hFFFFFFFF);
        check("addi_pc", dut.pc_r, 32'h30);
        step(); check("beq_taken_res", resultado, 32'd0);
        check("beq_taken_pc", dut.pc_r, 32'h3C);
        step(); check("beq_ntaken_res", resultado, 32'd2);
        check("beq_ntaken_pc", dut.pc_r, 32'h40);
        step(); check("addi_pos_res", resultado, 32'h77);
        step();
`ifdef JAL_EN
        check("jal_res", resultado, 32'h48);
        check("jal_reg31", dut.BR.registerBank[31], 32'h48);
`else
        check("op3_nop_res", resultado, 32'h77);
        check("op3_nop_reg31", dut.BR.registerBank[31], 32'd0);
`endif
        check("op3_pc", dut.pc_r, 32'h48);
        step(); check("j_pc", dut.pc_r, 32'h50);
`ifdef JAL_EN
        check("j_hold_res", resultado, 32'h48);
`else
        check("j_hold_res", resultado, 32'h77);
`endif
        step(); check("loop1_res", resultado, 32'd1);
        step(); check("loop_j_pc", dut.pc_r, 32'h50);
        check("loop_j_hold", resultado, 32'd1);
        step(); check("loop2_res", resultado, 32'd2);
        step();
        step(); check("loop3_res", resultado, 32'd3);
        check("skip_reg13", dut.BR.registerBank[13], 32'd0);

        #3;
        rst_CPU = 1'b1;
        #1;
        check("midreset_res", resultado, 32'd0);
        check("midreset_pc", dut.pc_r, 32'd0);
        check("midreset_reg1", dut.BR.registerBank[1], 32'd5);
        check("midreset_reg15", dut.BR.registerBank[15], 32'd3);
        @(negedge clk_CPU);
        rst_CPU = 1'b0;
        step(); check("restart_res", resultado, 32'd8);
        check("restart_pc", dut.pc_r, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cpu_control_rtype.md
Name: cpu_control_rtype

Overview:
- Single-cycle 32-bit MIPS-subset processor: PC, instruction memory, register bank, main control, ALU control, ALU and data memory.
- Executes R-type ALU ops, addi, lw, sw, beq and j, one instruction per clk_CPU cycle.
- Exposes the registered write-back value on resultado for observation.
- Submodule instance names and array names are fixed so benches can preload memories hierarchically: BR.registerBank, IM.instBank, DM.dataMemory.

Parameters:
- IM_DEPTH, 64, number of 32-bit words in IM.instBank.
- DM_DEPTH, 64, number of 32-bit words in DM.dataMemory.

Ports:
- clk_CPU  input  1  system clock; all state updates on the rising edge.
- rst_CPU  input  1  asynchronous active-high reset.
- resultado  output  32  registered write-back value of the last executed instruction.

Behaviour:
- Reset: while rst_CPU is high, PC=0 and resultado=0, applied immediately (asynchronous).
- Reset does not clear BR.registerBank, IM.instBank or DM.dataMemory; their contents come from preload.
- PC is a byte address. Instruction = IM.instBank[PC[7:2]]. Fetch is combinational.
- Register bank: 32x32 array registerBank, two combinational read ports, one write port written on the rising edge.
- Reading register 0 always returns 0. Writes to register 0 are ignored.
- Decode: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0] sign-extended to 32 bits.
- R-type (opcode 000000), destination rd:
  - funct 100000 add: rs+rt.
  - funct 100010 sub: rs-rt.
  - funct 100100 and: rs&rt.
  - funct 100101 or: rs|rt.
  - funct 100111 nor: ~(rs|rt).
  - funct 101010 slt: 1 if signed rs<rt, else 0.
  - Any other funct: no register write.
- addi (001000): rt = rs + simm.
- lw (100011): rt = DM.dataMemory[(rs+simm)[7:2]]. Read is combinational.
- sw (101011): DM.dataMemory[(rs+simm)[7:2]] = rt on the rising edge.
- beq (000100): if rs==rt, PC = PC+4+(simm<<2); otherwise PC = PC+4.
- j (000010): PC = {PC_plus4[31:28], target[25:0], 2'b00}.
- Any other opcode behaves as a nop: PC = PC+4, no register write, no memory write.
- Arithmetic is 32-bit wrap-around with no overflow trap.
- Address wrap: out-of-range word indices wrap modulo DEPTH through the low address bits.
- resultado on each rising edge (when not in reset):
  - register-writing instructions: resultado = the write-back data.
  - sw: resultado = the effective address.
  - beq: resultado = rs-rt.
  - j and nop: resultado holds its previous value.
- Ordering in one cycle: the register write and PC update land on the same edge. A following instruction reads the new value (single-cycle, no hazard).
- resultado and the register-bank write use the same write-back value.
- Reset asserted mid-program: PC returns to 0 immediately. Register and memory contents are retained. Execution restarts at address 0 after deassertion.

Optional Feature:
- Macro JAL_EN.
- Defined: opcode 000011 (jal) is decoded. It writes PC+4 to register 31, sets resultado = PC+4, and jumps exactly like j.
- Undefined: opcode 000011 is treated as a nop.

Test Plan:
- Reset: assert rst_CPU mid-cycle -> PC=0 and resultado=0 without waiting for a clock edge. Preloaded register values are unchanged after deassert.
- R-type sequence with $1=5, $2=3:
  - add $3,$1,$2 -> resultado=8
  - sub $4,$1,$2 -> 2
  - and -> 1
  - or -> 7
  - nor -> 0xFFFFFFF8
  - slt $5,$2,$1 -> 1
  - slt $5,$1,$2 -> 0
  - All values are also written to BR.registerBank.
- Register zero: add $0,$1,$2, then add $6,$0,$0 -> resultado=0 for the second instruction and registerBank[0] reads 0.
- Memory: with $1=5, sw $1,8($0) -> DM.dataMemory[2]=5 and resultado=8. Then lw $7,8($0) -> $7=5 and resultado=5.
- Control flow:
  - beq $1,$1,+2 at PC=0x10 -> next PC=0x1C.
  - beq with unequal operands -> next PC=0x14.
  - j 0x0000003 -> next PC=0x0C. A repeated loop re-executes the same instructions indefinitely.
- addi $8,$0,-1 -> resultado=0xFFFFFFFF. With JAL_EN defined, jal at PC=0x20 -> $31=0x24 and resultado=0x24.
